mac_result_writer: RTL and testbench

- Output stage directly downstream of the 4x4 MAC array.
- Accepts one result tile per handshake: one output row times four columns, as four 16-bit partial sums.
- Packs each tile into a 64-bit word and writes it to output SRAM (16 x 64b).
- When N>4 the tile's word was already written by an earlier K-pass; the block then does read-modify-write accumulation.
- Asserts DONE once the full T x M result matrix is in memory.

---
 rtl/mac_result_writer.sv | 212 +++++++++++++++++++++
 tb/tb_mac_result_writer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_result_writer.sv
// mac_result_writer: packs 4-lane MAC result tiles into 64b words and
// writes them to a 16x64 output SRAM, doing read-modify-write when a
// tile's word was already written by an earlier K-pass.
// Ports: CLK/RSTN clock and async active-low reset; MNT job config
// (N=[11:8], M=[7:4], T=[3:0]) sampled on START; RES_* tile handshake;
// EN_O/RW_O/ADDR_O/WDATA_O/RDATA_O memory port; BUSY/DONE/ERR status.
module mac_result_writer #(
  parameter int LANE_W  = 16,
  parameter int OADDR_W = 4
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic [11:0]         MNT,
  input  logic                START,
  input  logic                RES_VALID,
  output logic                RES_READY,
  input  logic [2:0]          RES_ROW,
  input  logic                RES_CTILE,
  input  logic [4*LANE_W-1:0] RES_DATA,
  output logic                EN_O,
  output logic                RW_O,
  output logic [OADDR_W-1:0]  ADDR_O,
  output logic [4*LANE_W-1:0] WDATA_O,
  input  logic [4*LANE_W-1:0] RDATA_O,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERR
);

  localparam int W     = 4 * LANE_W;
  localparam int WORDS = 1 << OADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    RD,
    ADD,
    WR,
    FIN
  } state_t;

  state_t             state;
  logic [3:0]         n_q;
  logic [3:0]         m_q;
  logic [3:0]         t_q;
  logic [6:0]         exp_q;
  logic [6:0]         cnt_q;
  logic [WORDS-1:0]   bitmap_q;
  logic [OADDR_W-1:0] addr_q;
  logic [W-1:0]       data_q;

  logic [3:0]         cfg_n;
  logic [3:0]         cfg_m;
  logic [3:0]         cfg_t;
  logic               cfg_bad;
  logic [6:0]         ceil_m;
  logic [6:0]         ceil_n;
  logic [6:0]         exp_nxt;
  logic [OADDR_W-1:0] addr_in;
  logic               tile_bad;
  logic [W-1:0]       mask_data;
  logic [W-1:0]       sum_data;
  logic [6:0]         cnt_inc;

  assign cfg_n = MNT[11:8];
  assign cfg_m = MNT[7:4];
  assign cfg_t = MNT[3:0];

  assign cfg_bad = (cfg_n == 4'd0) || (cfg_n > 4'd8) ||
                   (cfg_m == 4'd0) || (cfg_m > 4'd8) ||
                   (cfg_t == 4'd0) || (cfg_t > 4'd8);

  // With dimensions capped at 8, ceil(x/4) is 1 or 2.
  assign ceil_m  = (cfg_m > 4'd4) ? 7'd2 : 7'd1;
  assign ceil_n  = (cfg_n > 4'd4) ? 7'd2 : 7'd1;
  assign exp_nxt = 7'(cfg_t) * ceil_m * ceil_n;

  assign addr_in = OADDR_W'({RES_ROW, RES_CTILE});
  assign cnt_inc = cnt_q + 7'd1;

  assign tile_bad = ({1'b0, RES_ROW} >= t_q) ||
                    (RES_CTILE && (m_q <= 4'd4));

  // Lane c carries column 4*CTILE+c; columns at or beyond M are zeroed.
  always_comb begin
    mask_data = '0;
    for (int c = 0; c < 4; c++) begin
      if ({1'b0, RES_CTILE, 2'(c)} < m_q) begin
        mask_data[W-1-LANE_W*c -: LANE_W] =
          RES_DATA[W-1-LANE_W*c -: LANE_W];
      end
    end
  end

  // Independent per-lane adders: carries never cross lane boundaries.
  always_comb begin
    sum_data = '0;
    for (int c = 0; c < 4; c++) begin
      sum_data[W-1-LANE_W*c -: LANE_W] =
        data_q[W-1-LANE_W*c -: LANE_W] +
        RDATA_O[W-1-LANE_W*c -: LANE_W];
    end
  end

  // Outputs are registered alongside the state they belong to, so each
  // transition loads the output values of the state being entered.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      RES_READY <= 1'b0;
      EN_O      <= 1'b0;
      RW_O      <= 1'b0;
      ADDR_O    <= '0;
      WDATA_O   <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      n_q       <= '0;
      m_q       <= '0;
      t_q       <= '0;
      exp_q     <= '0;
      cnt_q     <= '0;
      bitmap_q  <= '0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      EN_O    <= 1'b0;
      RW_O    <= 1'b0;
      ADDR_O  <= '0;
      WDATA_O <= '0;
      DONE    <= 1'b0;
      unique case (state)
        IDLE: begin
          RES_READY <= 1'b0;
          BUSY      <= 1'b0;
          if (START) begin
            n_q      <= cfg_n;
            m_q      <= cfg_m;
            t_q      <= cfg_t;
            exp_q    <= exp_nxt;
            cnt_q    <= '0;
            bitmap_q <= '0;
            ERR      <= cfg_bad;
            if (cfg_bad) begin
              state <= FIN;
              DONE  <= 1'b1;
            end else begin
              state     <= ACCEPT;
              RES_READY <= 1'b1;
              BUSY      <= 1'b1;
            end
          end
        end
        ACCEPT: begin
          if (RES_VALID) begin
            if (tile_bad) begin
              ERR <= 1'b1;
            end else begin
              addr_q    <= addr_in;
              data_q    <= mask_data;
              RES_READY <= 1'b0;
              EN_O      <= 1'b1;
              ADDR_O    <= addr_in;
              if (!bitmap_q[addr_in]) begin
                state   <= WR;
                RW_O    <= 1'b1;
                WDATA_O <= mask_data;
              end else begin
                state <= RD;
              end
            end
          end
        end
        RD: begin
          state <= ADD;
        end
        ADD: begin
          state   <= WR;
          EN_O    <= 1'b1;
          RW_O    <= 1'b1;
          ADDR_O  <= addr_q;
          WDATA_O <= sum_data;
        end
        WR: begin
          bitmap_q[addr_q] <= 1'b1;
          cnt_q            <= cnt_inc;
          if (cnt_inc == exp_q) begin
            state <= FIN;
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
          end else begin
            state     <= ACCEPT;
            RES_READY <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          RES_READY <= 1'b0;
          BUSY      <= 1'b0;
        end
      endcase
    end
  end

  logic unused_n;
  assign unused_n = ^n_q;

endmodule

// File: tb/tb_mac_result_writer.sv
// tb_mac_result_writer: scoreboard bench for mac_result_writer with a
// behavioural 16x64 output SRAM and a reference memory model.
`timescale 1ns/1ps
module tb_mac_result_writer;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic [11:0] MNT = '0;
  logic        START = 1'b0;
  logic        RES_VALID = 1'b0;
  logic        RES_READY;
  logic [2:0]  RES_ROW = '0;
  logic        RES_CTILE = 1'b0;
  logic [63:0] RES_DATA = '0;
  logic        EN_O;
  logic        RW_O;
  logic [3:0]  ADDR_O;
  logic [63:0] WDATA_O;
  logic [63:0] RDATA_O = '0;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  mac_result_writer #(.LANE_W(16), .OADDR_W(4)) dut (
    .CLK(CLK), .RSTN(RSTN), .MNT(MNT), .START(START),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .RES_ROW(RES_ROW), .RES_CTILE(RES_CTILE), .RES_DATA(RES_DATA),
    .EN_O(EN_O), .RW_O(RW_O), .ADDR_O(ADDR_O), .WDATA_O(WDATA_O),
    .RDATA_O(RDATA_O), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  logic [63:0] mem [16];
  always @(posedge CLK) begin
    if (EN_O && RW_O) mem[ADDR_O] <= WDATA_O;
    if (EN_O && !RW_O) RDATA_O <= mem[ADDR_O];
  end

  typedef struct {
    logic [3:0]  addr;
    logic [63:0] data;
    bit          rmw;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] ref_mem [16];
  logic [15:0] ref_wr;
  logic [3:0]  cur_n, cur_m, cur_t;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int hs_cyc = 0, rd_cyc = 0, last_wr = 0, done_cyc = 0, s_cyc = 0;
  int done_cnt = 0, en_cnt = 0, wr_cnt = 0;
  logic [3:0] rd_addr = '0;
  logic done_prev = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mask(input logic [63:0] d,
                                       input logic ct,
                                       input logic [3:0] m);
    logic [63:0] r;
    int col;
    r = d;
    for (int c = 0; c < 4; c++) begin
      col = (ct ? 4 : 0) + c;
      if (col >= int'(m)) r[63-16*c -: 16] = 16'h0;
    end
    return r;
  endfunction

  function automatic logic [63:0] lane_add(input logic [63:0] a,
                                           input logic [63:0] b);
    logic [63:0] r;
    logic [16:0] s;
    for (int c = 0; c < 4; c++) begin
      s = {1'b0, a[16*c +: 16]} + {1'b0, b[16*c +: 16]};
      r[16*c +: 16] = s[15:0];
    end
    return r;
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  exp_t e;
  always @(negedge CLK) begin
    if (RSTN) begin
      if (DONE) begin
        check("done_pulse", 64'(done_prev), 64'd0);
        done_cnt++;
        done_cyc = cyc;
      end
      done_prev = DONE;
      if (RES_VALID && RES_READY) hs_cyc = cyc;
      if (EN_O) en_cnt++;
      if (EN_O && !RW_O) begin
        rd_cyc = cyc;
        rd_addr = ADDR_O;
      end
      if (!EN_O) check("wdata_idle", WDATA_O, 64'd0);
      if (EN_O && RW_O) begin
        wr_cnt++;
        check("wr_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("wr_addr", 64'(ADDR_O), 64'(e.addr));
          check("wr_data", WDATA_O, e.data);
          if (e.rmw) begin
            check("rd_addr", 64'(rd_addr), 64'(e.addr));
            check("rd_lat", 64'(rd_cyc - hs_cyc), 64'd1);
            check("rmw_lat", 64'(cyc - hs_cyc), 64'd3);
          end else begin
            check("wr_lat", 64'(cyc - hs_cyc), 64'd1);
          end
        end
        last_wr = cyc;
      end
    end else begin
      done_prev = 1'b0;
    end
  end

  task automatic do_start(input logic [11:0] mnt);
    @(posedge CLK); #1;
    MNT = mnt;
    START = 1'b1;
    cur_n = mnt[11:8];
    cur_m = mnt[7:4];
    cur_t = mnt[3:0];
    ref_wr = '0;
    @(negedge CLK);
    s_cyc = cyc;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic send_tile(input logic [2:0] row, input logic ct,
                           input logic [63:0] d);
    logic [3:0]  a;
    logic [63:0] md, nv;
    int n;
    a = {row, ct};
    if ({1'b0, row} < cur_t && !(ct && cur_m <= 4'd4)) begin
      md = mask(d, ct, cur_m);
      if (ref_wr[a]) begin
        nv = lane_add(ref_mem[a], md);
        sb.push_back('{a, nv, 1'b1});
      end else begin
        nv = md;
        sb.push_back('{a, nv, 1'b0});
      end
      ref_mem[a] = nv;
      ref_wr[a] = 1'b1;
    end
    RES_VALID = 1'b1;
    RES_ROW = row;
    RES_CTILE = ct;
    RES_DATA = d;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (RES_READY !== 1'b1 && n < 50);
    check("hs_timeout", 64'(n < 50), 64'd1);
    @(posedge CLK); #1;
    RES_VALID = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    int d0;
    n = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_done"}, 64'(done_cnt != d0), 64'd1);
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int en0, wr0;

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    ref_wr = '0;
    cur_n = '0;
    cur_m = '0;
    cur_t = '0;

    #12;
    check("rst_outs",
          64'({EN_O, RW_O, RES_READY, BUSY, DONE, ERR}), 64'd0);
    check("rst_addr_wdata", {WDATA_O[63:4], ADDR_O}, 64'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);
    check("idle_ready", 64'({RES_READY, BUSY}), 64'd0);

    wr0 = wr_cnt;
    do_start(12'h444);
    check("t1_busy", 64'(BUSY), 64'd1);
    for (int r = 0; r < 4; r++)
      send_tile(3'(r), 1'b0, 64'h0001_0002_0003_0004);
    wait_done("t1");
    check("t1_done_lat", 64'(done_cyc - last_wr), 64'd1);
    check("t1_writes", 64'(wr_cnt - wr0), 64'd4);
    check("t1_err", 64'(ERR), 64'd0);
    check("t1_idle", 64'({BUSY, RES_READY}), 64'd0);

    wr0 = wr_cnt;
    do_start(12'h878);
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 2; c++)
          send_tile(3'(r), 1'(c), 64'h0010_0010_0010_0010);
    wait_done("t2");
    check("t2_done_lat", 64'(done_cyc - last_wr), 64'd1);
    check("t2_writes", 64'(wr_cnt - wr0), 64'd32);
    check("t2_mem1", mem[1], 64'h0020_0020_0020_0000);
    check("t2_mem15", mem[15], 64'h0020_0020_0020_0000);
    check("t2_mem6", mem[6], 64'h0020_0020_0020_0020);
    check("t2_err", 64'(ERR), 64'd0);

    do_start(12'h841);
    send_tile(3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    send_tile(3'd0, 1'b0, 64'h0002_0002_0002_0002);
    wait_done("t3");
    check("t3_mem0", mem[0], 64'h0001_0001_0001_0001);

    wr0 = wr_cnt;
    do_start(12'h442);
    en0 = en_cnt;
    send_tile(3'd3, 1'b0, 64'h1111_1111_1111_1111);
    @(negedge CLK);
    check("t4_err_row", 64'(ERR), 64'd1);
    check("t4_no_en", 64'(en_cnt - en0), 64'd0);
    send_tile(3'd0, 1'b1, 64'h2222_2222_2222_2222);
    check("t4_no_en_ct", 64'(en_cnt - en0), 64'd0);
    send_tile(3'd0, 1'b0, 64'h0003_0004_0005_0006);
    send_tile(3'd1, 1'b0, 64'h0007_0008_0009_000A);
    wait_done("t4");
    check("t4_writes", 64'(wr_cnt - wr0), 64'd2);
    check("t4_err_sticky", 64'(ERR), 64'd1);
    check("t4_row3_kept", mem[6], 64'h0020_0020_0020_0020);
    check("t4_mem0", mem[0], 64'h0003_0004_0005_0006);

    en0 = en_cnt;
    do_start(12'h904);
    wait_done("t5");
    check("t5_lat_ok",
          64'((done_cyc - s_cyc >= 1) && (done_cyc - s_cyc <= 2)), 64'd1);
    check("t5_err", 64'(ERR), 64'd1);
    check("t5_no_en", 64'(en_cnt - en0), 64'd0);

    do_start(12'h811);
    check("t6_err_clr", 64'(ERR), 64'd0);
    send_tile(3'd0, 1'b0, 64'h0005_0006_0007_0008);
    send_tile(3'd0, 1'b0, 64'h0003_0003_0003_0003);
    check("t6_in_rd", 64'({EN_O, RW_O}), 64'b10);
    RSTN = 1'b0;
    #1;
    check("t6_abort", 64'({EN_O, BUSY, RES_READY}), 64'd0);
    sb.delete();
    ref_mem[0] = 64'h0005_0000_0000_0000;
    @(negedge CLK);
    check("t6_no_partial", mem[0], 64'h0005_0000_0000_0000);
    RSTN = 1'b1;
    do_start(12'h111);
    send_tile(3'd0, 1'b0, 64'h1234_5678_9ABC_DEF0);
    wait_done("t6");
    check("t6_mem0", mem[0], 64'h1234_0000_0000_0000);

    repeat (3) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
